tv80_dma_busmaster: RTL

- Block-copy DMA engine that shares the tv80s memory bus with the CPU through the busrq_n/busak_n handshake.
- Software supplies src, dst and len, then pulses start. The block requests the bus, copies bytes with one read and one write per byte, and releases the bus after every BURST bytes so the CPU can run.
- Sits beside tv80s. The top level muxes A/dout/mreq_n/rd_n/wr_n onto the memory with dma_en.

---
 rtl/tv80_dma_busmaster_if.sv | 36 +++
 rtl/tv80_dma_busmaster.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tv80_dma_busmaster_if.sv
// Command and bus-side signals of the tv80 block-copy DMA engine.
//   Command side: start, src, dst, len go in; busy, done, err come out.
//   Bus side: busrq_n/busak_n handshake with the CPU, plus the memory strobes,
//   address and data that the top level muxes onto memory with dma_en.
// master : the DMA engine's view.
// slave  : the view of the surrounding system (software, CPU, memory).
interface tv80_dma_busmaster_if;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        busrq_n;
    logic        busak_n;
    logic        dma_en;
    logic [15:0] dma_a;
    logic [7:0]  dma_do;
    logic [7:0]  dma_di;
    logic        dma_mreq_n;
    logic        dma_rd_n;
    logic        dma_wr_n;

    modport master (
        input  start, src, dst, len, busak_n, dma_di,
        output busy, done, err, busrq_n, dma_en, dma_a, dma_do,
               dma_mreq_n, dma_rd_n, dma_wr_n
    );

    modport slave (
        output start, src, dst, len, busak_n, dma_di,
        input  busy, done, err, busrq_n, dma_en, dma_a, dma_do,
               dma_mreq_n, dma_rd_n, dma_wr_n
    );
endinterface

// File: rtl/tv80_dma_busmaster.sv
// Block-copy DMA engine sharing the tv80s memory bus with the CPU.
// Software loads src/dst/len and pulses start. The engine requests the bus,
// copies one byte per read+write pair (2 clk/byte), and hands the bus back
// to the CPU after every BURST bytes, waiting GAP cycles before re-requesting.
// A grant that never arrives within GRANT_TIMEOUT cycles aborts with err.
// Ports:
//   clk   - system clock, shared with the CPU
//   reset - synchronous, active-high
//   bus   - tv80_dma_busmaster_if.master (command/status + memory bus)
// All outputs are registered.
module tv80_dma_busmaster #(
    parameter int BURST         = 8,
    parameter int GAP           = 4,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    tv80_dma_busmaster_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_WR, S_YIELD, S_FIN
    } state_t;

    localparam logic [7:0]  BURST_LAST = 8'(BURST - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP - 1);
    localparam logic [15:0] TO_LAST    = 16'(GRANT_TIMEOUT - 1);

    state_t      state;
    logic [15:0] src_cur;
    logic [15:0] dst_cur;
    logic [15:0] remaining;
    logic [7:0]  burst_cnt;
    logic [7:0]  gap_cnt;
    logic [15:0] wait_cnt;
    logic        released;   // CPU has taken the bus back during YIELD

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            src_cur        <= '0;
            dst_cur        <= '0;
            remaining      <= '0;
            burst_cnt      <= '0;
            gap_cnt        <= '0;
            wait_cnt       <= '0;
            released       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.busrq_n    <= 1'b1;
            bus.dma_en     <= 1'b0;
            bus.dma_a      <= '0;
            bus.dma_do     <= '0;
            bus.dma_mreq_n <= 1'b1;
            bus.dma_rd_n   <= 1'b1;
            bus.dma_wr_n   <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.err <= 1'b0;
                        if (bus.len != 16'd0) begin
                            src_cur     <= bus.src;
                            dst_cur     <= bus.dst;
                            remaining   <= bus.len;
                            burst_cnt   <= '0;
                            wait_cnt    <= '0;
                            bus.busy    <= 1'b1;
                            bus.busrq_n <= 1'b0;
                            state       <= S_REQ;
                        end else begin
                            // Empty copy: complete immediately, never touch the bus.
                            bus.done <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (!bus.busak_n) begin
                        // Outputs for the RD cycle are set up here so they are
                        // registered and valid for the whole read cycle.
                        bus.dma_en     <= 1'b1;
                        bus.dma_a      <= src_cur;
                        bus.dma_mreq_n <= 1'b0;
                        bus.dma_rd_n   <= 1'b0;
                        state          <= S_RD;
                    end else if (GRANT_TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                        bus.err     <= 1'b1;
                        bus.busrq_n <= 1'b1;
                        state       <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                S_RD: begin
                    // dma_do doubles as the data register: the byte read now is
                    // driven straight out during the following write cycle.
                    bus.dma_do   <= bus.dma_di;
                    bus.dma_a    <= dst_cur;
                    bus.dma_rd_n <= 1'b1;
                    bus.dma_wr_n <= 1'b0;
                    state        <= S_WR;
                end

                S_WR: begin
                    src_cur      <= src_cur + 16'd1;
                    dst_cur      <= dst_cur + 16'd1;
                    remaining    <= remaining - 16'd1;
                    bus.dma_wr_n <= 1'b1;
                    if (remaining == 16'd1 || burst_cnt == BURST_LAST) begin
                        // End of tenure: drop the bus in the same edge as the request.
                        bus.dma_en     <= 1'b0;
                        bus.dma_mreq_n <= 1'b1;
                        bus.busrq_n    <= 1'b1;
                        burst_cnt      <= '0;
                        gap_cnt        <= '0;
                        released       <= 1'b0;
                        state          <= (remaining == 16'd1) ? S_FIN : S_YIELD;
                    end else begin
                        burst_cnt    <= burst_cnt + 8'd1;
                        bus.dma_a    <= src_cur + 16'd1;
                        bus.dma_rd_n <= 1'b0;
                        state        <= S_RD;
                    end
                end

                S_YIELD: begin
                    // The GAP count starts with the first cycle busak_n is seen high,
                    // so the CPU always gets at least GAP cycles of its own.
                    if (bus.busak_n || released) begin
                        released <= 1'b1;
                        if (gap_cnt == GAP_LAST) begin
                            bus.busrq_n <= 1'b0;
                            wait_cnt    <= '0;
                            state       <= S_REQ;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end

                S_FIN: begin
                    if (bus.busak_n) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
